// File: rtl/traffic_pkg.sv
// Shared light codes, direction index and FSM state encoding for the traffic-light controller.
// TRAFFIC_ALL_RED_EN adds the all-red clearance state to the encoding.
package traffic_pkg;

  localparam logic [1:0] LT_RED    = 2'b00;
  localparam logic [1:0] LT_GREEN  = 2'b01;
  localparam logic [1:0] LT_YELLOW = 2'b10;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_E = 2'd0;
  localparam dir_t DIR_S = 2'd1;
  localparam dir_t DIR_W = 2'd2;
  localparam dir_t DIR_N = 2'd3;

  typedef enum logic [3:0] {
    StIdle,
    StEG, StEY,
    StSG, StSY,
    StWG, StWY,
    StNG, StNY
`ifdef TRAFFIC_ALL_RED_EN
    , StAllRed
`endif
  } state_e;

  function automatic dir_t state_dir(state_e s);
    case (s)
      StSG, StSY: return DIR_S;
      StWG, StWY: return DIR_W;
      StNG, StNY: return DIR_N;
      default:    return DIR_E;
    endcase
  endfunction

  function automatic state_e green_of(dir_t d);
    case (d)
      DIR_E:   return StEG;
      DIR_S:   return StSG;
      DIR_W:   return StWG;
      default: return StNG;
    endcase
  endfunction

  function automatic state_e yellow_of(state_e s);
    case (s)
      StEG:    return StEY;
      StSG:    return StSY;
      StWG:    return StWY;
      default: return StNY;
    endcase
  endfunction

  function automatic logic is_green(state_e s);
    return (s == StEG) || (s == StSG) || (s == StWG) || (s == StNG);
  endfunction

  function automatic logic is_yellow(state_e s);
    return (s == StEY) || (s == StSY) || (s == StWY) || (s == StNY);
  endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// Prescaler: tick is high in the cycle the count equals TICK_DIV-1, then the count wraps.
module traffic_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == CntLast)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign tick = (r_cnt == CntLast);

endmodule

// File: rtl/traffic_top.sv
// Four-way round-robin traffic-light controller (E, S, W, N) with registered light/countdown outputs.
// Define TRAFFIC_ALL_RED_EN to insert an all-red clearance phase after every yellow.
module traffic_top
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_T  = 8,
  parameter int unsigned YELLOW_T = 2,
  parameter int unsigned ALLRED_T = 1,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_start,
  output logic [3:0] o_e_ct,
  output logic [3:0] o_w_ct,
  output logic [3:0] o_s_ct,
  output logic [3:0] o_n_ct,
  output logic [1:0] o_e_wt,
  output logic [1:0] o_w_wt,
  output logic [1:0] o_s_wt,
  output logic [1:0] o_n_wt
);

  localparam logic [3:0] GreenCt  = 4'(GREEN_T);
  localparam logic [3:0] YellowCt = 4'(YELLOW_T);
  // An out-of-range timing configuration keeps the controller parked in IDLE.
  localparam bit CfgOk = (GREEN_T >= 1) && (GREEN_T <= 15) && (YELLOW_T >= 1) &&
                         (YELLOW_T <= 15) && (ALLRED_T >= 1) && (ALLRED_T <= 15) &&
                         (TICK_DIV >= 1);

  state_e          r_state, w_state_d;
  logic [3:0]      r_ct, w_ct_d;
  logic [3:0][1:0] r_wt, w_wt_d;
  logic [3:0][3:0] r_cto, w_cto_d;
  logic            w_tick;

`ifdef TRAFFIC_ALL_RED_EN
  localparam logic [3:0] AllRedCt = 4'(ALLRED_T);
  logic [3:0] r_clr_ct, w_clr_ct_d;
  dir_t       r_nxt_dir, w_nxt_dir_d;
`endif

  traffic_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (r_state == StIdle),
    .tick    (w_tick)
  );

  always_comb begin
    w_state_d = r_state;
    w_ct_d    = r_ct;
`ifdef TRAFFIC_ALL_RED_EN
    w_clr_ct_d  = r_clr_ct;
    w_nxt_dir_d = r_nxt_dir;
`endif
    unique case (r_state)
      StIdle: begin
        if (i_start && CfgOk) begin
          w_state_d = StEG;
          w_ct_d    = GreenCt;
        end
      end
      StEG, StSG, StWG, StNG: begin
        if (w_tick) begin
          if (r_ct > 4'd1) begin
            w_ct_d = r_ct - 4'd1;
          end else begin
            w_state_d = yellow_of(r_state);
            w_ct_d    = YellowCt;
          end
        end
      end
      StEY, StSY, StWY, StNY: begin
        if (w_tick) begin
          if (r_ct > 4'd1) begin
            w_ct_d = r_ct - 4'd1;
          end else begin
`ifdef TRAFFIC_ALL_RED_EN
            w_state_d   = StAllRed;
            w_ct_d      = '0;
            w_clr_ct_d  = AllRedCt;
            w_nxt_dir_d = dir_t'(state_dir(r_state) + 2'd1);
`else
            w_state_d = green_of(dir_t'(state_dir(r_state) + 2'd1));
            w_ct_d    = GreenCt;
`endif
          end
        end
      end
`ifdef TRAFFIC_ALL_RED_EN
      StAllRed: begin
        if (w_tick) begin
          if (r_clr_ct > 4'd1) begin
            w_clr_ct_d = r_clr_ct - 4'd1;
          end else begin
            w_state_d = green_of(r_nxt_dir);
            w_ct_d    = GreenCt;
          end
        end
      end
`endif
      default: begin
        w_state_d = StIdle;
        w_ct_d    = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_wt_d  = '0;
    w_cto_d = '0;
    if (is_green(w_state_d) || is_yellow(w_state_d)) begin
      w_wt_d[state_dir(w_state_d)]  = is_green(w_state_d) ? LT_GREEN : LT_YELLOW;
      w_cto_d[state_dir(w_state_d)] = w_ct_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_ct    <= '0;
      r_wt    <= '0;
      r_cto   <= '0;
`ifdef TRAFFIC_ALL_RED_EN
      r_clr_ct  <= '0;
      r_nxt_dir <= DIR_E;
`endif
    end else begin
      r_state <= w_state_d;
      r_ct    <= w_ct_d;
      r_wt    <= w_wt_d;
      r_cto   <= w_cto_d;
`ifdef TRAFFIC_ALL_RED_EN
      r_clr_ct  <= w_clr_ct_d;
      r_nxt_dir <= w_nxt_dir_d;
`endif
    end
  end

  assign o_e_wt = r_wt[DIR_E];
  assign o_s_wt = r_wt[DIR_S];
  assign o_w_wt = r_wt[DIR_W];
  assign o_n_wt = r_wt[DIR_N];
  assign o_e_ct = r_cto[DIR_E];
  assign o_s_ct = r_cto[DIR_S];
  assign o_w_ct = r_cto[DIR_W];
  assign o_n_ct = r_cto[DIR_N];

endmodule

// File: tb/tb_traffic_top.sv
// Directed bench for traffic_top: default-timing instance plus a TICK_DIV=3 instance on shared inputs.
module tb_traffic_top;

`ifdef TRAFFIC_ALL_RED_EN
  localparam int Per = 11;
`else
  localparam int Per = 10;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic i_start;

  logic [3:0] e_ct, w_ct, s_ct, n_ct;
  logic [1:0] e_wt, w_wt, s_wt, n_wt;
  logic [3:0] e_ct3, w_ct3, s_ct3, n_ct3;
  logic [1:0] e_wt3, w_wt3, s_wt3, n_wt3;

  logic [3:0][1:0] wt_all;
  logic [3:0][3:0] ct_all;
  assign wt_all = {n_wt, w_wt, s_wt, e_wt};
  assign ct_all = {n_ct, w_ct, s_ct, e_ct};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  traffic_top dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (i_start),
    .o_e_ct  (e_ct),
    .o_w_ct  (w_ct),
    .o_s_ct  (s_ct),
    .o_n_ct  (n_ct),
    .o_e_wt  (e_wt),
    .o_w_wt  (w_wt),
    .o_s_wt  (s_wt),
    .o_n_wt  (n_wt)
  );

  traffic_top #(
    .TICK_DIV (3)
  ) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (i_start),
    .o_e_ct  (e_ct3),
    .o_w_ct  (w_ct3),
    .o_s_ct  (s_ct3),
    .o_n_ct  (n_ct3),
    .o_e_wt  (e_wt3),
    .o_w_wt  (w_wt3),
    .o_s_wt  (s_wt3),
    .o_n_wt  (n_wt3)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_idle(input string tag);
    chk({tag, " e_wt"}, {2'b00, e_wt}, 4'h0);
    chk({tag, " s_wt"}, {2'b00, s_wt}, 4'h0);
    chk({tag, " w_wt"}, {2'b00, w_wt}, 4'h0);
    chk({tag, " n_wt"}, {2'b00, n_wt}, 4'h0);
    chk({tag, " ct"}, e_ct | s_ct | w_ct | n_ct, 4'h0);
    chk({tag, " dut3 wt"}, {2'b00, e_wt3 | s_wt3 | w_wt3 | n_wt3}, 4'h0);
    chk({tag, " dut3 ct"}, e_ct3 | s_ct3 | w_ct3 | n_ct3, 4'h0);
  endtask

  // k counts cycles since E_G entry; hand timing: 8 green, 2 yellow, optional 1 all-red.
  task automatic chk_cycle(input int k);
    logic [3:0][1:0] exp_wt;
    logic [3:0][3:0] exp_ct;
    int p, d, nonred, greens, exp_nonred, exp_greens;
    p = k % Per;
    d = (k / Per) % 4;
    exp_wt = '0;
    exp_ct = '0;
    if (p < 8) begin
      exp_wt[d] = 2'b01;
      exp_ct[d] = 4'(8 - p);
    end else if (p < 10) begin
      exp_wt[d] = 2'b10;
      exp_ct[d] = 4'(10 - p);
    end
    nonred = 0;
    greens = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("k%0d wt[%0d]", k, i), {2'b00, wt_all[i]}, {2'b00, exp_wt[i]});
      chk($sformatf("k%0d ct[%0d]", k, i), ct_all[i], exp_ct[i]);
      if (wt_all[i] != 2'b00) nonred++;
      if (wt_all[i] == 2'b01) greens++;
    end
    exp_nonred = (p < 10) ? 1 : 0;
    exp_greens = (p < 8) ? 1 : 0;
    chk($sformatf("k%0d nonred count", k), 4'(nonred), 4'(exp_nonred));
    chk($sformatf("k%0d green count", k), 4'(greens), 4'(exp_greens));
    if (k < 24) begin
      chk($sformatf("k%0d div3 e_wt", k), {2'b00, e_wt3}, 4'h1);
      chk($sformatf("k%0d div3 e_ct", k), e_ct3, 4'(8 - k / 3));
    end else if (k < 30) begin
      chk($sformatf("k%0d div3 e_wt", k), {2'b00, e_wt3}, 4'h2);
      chk($sformatf("k%0d div3 e_ct", k), e_ct3, 4'(2 - (k - 24) / 3));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    i_start = 1'b0;
    #1;
    chk_all_idle("reset");
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk_all_idle("idle hold");

    i_start = 1'b1;
    step();
    for (int k = 0; k <= 4 * Per; k++) begin
      chk_cycle(k);
      if (k < 4 * Per) step();
    end

    // Move into W_G with three ticks elapsed.
    for (int i = 0; i < 2 * Per + 3; i++) step();
    chk("pre-reset w_wt", {2'b00, w_wt}, 4'h1);
    chk("pre-reset w_ct", w_ct, 4'h5);

    reset_n = 1'b0;
    #1;
    chk_all_idle("async reset");
    step();
    chk_all_idle("reset held");
    reset_n = 1'b1;
    step();
    chk("restart e_wt", {2'b00, e_wt}, 4'h1);
    chk("restart e_ct", e_ct, 4'h8);
    chk("restart w_wt", {2'b00, w_wt}, 4'h0);
    chk("restart div3 e_ct", e_ct3, 4'h8);
    step();
    step();
    chk("restart+2 e_ct", e_ct, 4'h6);
    chk("restart+2 div3 e_ct", e_ct3, 4'h8);
    step();
    chk("restart+3 e_ct", e_ct, 4'h5);
    chk("restart+3 div3 e_ct", e_ct3, 4'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
